// File: rtl/toivoh_pkg.sv
// Shared definitions for the streaming adder: FSM state encoding and the
// bit positions of the handshake/status signals on the bidirectional port.
package toivoh_pkg;

    typedef enum logic [1:0] {
        ST_LOAD    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_SEND    = 2'd2
    } state_t;

    // uio_in handshake inputs
    localparam int UIO_IN_VALID  = 0;
    localparam int UIO_OUT_READY = 1;

    // uio_out status outputs
    localparam int UIO_IN_READY  = 2;
    localparam int UIO_OUT_VALID = 3;
    localparam int UIO_BUSY      = 4;
    localparam int UIO_CARRY     = 5;

    localparam logic [7:0] UIO_OE_MASK = 8'b0011_1100;

endpackage

// File: rtl/tt_um_toivoh_stream_tx_edge_sync.sv
// Two-flop synchronizer followed by a rising-edge detector producing a
// one-cycle pulse per 0->1 pin transition.
module edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic i_pin,
    output logic o_pulse
);

    logic       r_meta;
    logic       r_sync;
    logic       r_prev;
    logic [1:0] r_fill;
    logic       r_armed;

    // r_fill marks when r_sync reflects the real pin rather than reset zeros;
    // r_armed then requires one genuine low before any edge can be reported,
    // so a pin already high when reset lifts stays silent until it toggles.
    // NOTE: every flop here uses <= so the chain shifts by exactly one stage per edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta  <= 1'b0;
            r_sync  <= 1'b0;
            r_prev  <= 1'b0;
            r_fill  <= 2'b00;
            r_armed <= 1'b0;
        end else begin
            r_meta  <= i_pin;
            r_sync  <= r_meta;
            r_prev  <= r_sync;
            r_fill  <= {r_fill[0], 1'b1};
            r_armed <= r_armed | (r_fill[1] & ~r_sync);
        end
    end

    assign o_pulse = r_sync & ~r_prev & r_armed;

endmodule

// File: rtl/tt_um_toivoh_stream_tx.sv
// Byte-serial adder: loads x|y operand bytes over a valid handshake, adds the
// halves with a ripple-carry adder and streams the sum out LSB byte first.
module tt_um_toivoh_stream_tx
    import toivoh_pkg::*;
#(
    parameter int LOG2_BYTES_IN  = 3,
    parameter int LOG2_BYTES_OUT = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int BYTES_IN  = 1 << LOG2_BYTES_IN;
    localparam int BITS_IN   = 8 * BYTES_IN;
    localparam int HALF      = BITS_IN / 2;
    localparam int BYTES_OUT = 1 << LOG2_BYTES_OUT;
    localparam int BITS_OUT  = 8 * BYTES_OUT;

    state_t                    r_state;
    state_t                    w_next;
    logic [LOG2_BYTES_IN-1:0]  r_load_cnt;
    logic [LOG2_BYTES_OUT-1:0] r_send_cnt;
    logic [BITS_IN-1:0]        r_operand;
    logic [BITS_OUT-1:0]       r_result;
    logic                      r_carry;

    logic w_in_evt;
    logic w_out_evt;
    logic w_load_last;
    logic w_send_last;
    logic w_unused;

    assign w_unused = &{1'b0, ena, uio_in[7:2]};

    edge_sync u_in_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_pin   (uio_in[UIO_IN_VALID]),
        .o_pulse (w_in_evt)
    );

    edge_sync u_out_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_pin   (uio_in[UIO_OUT_READY]),
        .o_pulse (w_out_evt)
    );

    assign w_load_last = (r_load_cnt == LOG2_BYTES_IN'(BYTES_IN - 1));
    assign w_send_last = (r_send_cnt == LOG2_BYTES_OUT'(BYTES_OUT - 1));

    // Ripple-carry adder over the low BITS_OUT bits of each operand half.
    logic [BITS_OUT:0]   w_c;
    logic [BITS_OUT-1:0] w_a;
    logic [BITS_OUT-1:0] w_b;
    logic [BITS_OUT-1:0] w_sum;

    assign w_c[0] = 1'b0;

    for (genvar i = 0; i < BITS_OUT; i++) begin : g_rca
        if (i < HALF) begin : g_op
            assign w_a[i] = r_operand[i];
            assign w_b[i] = r_operand[HALF + i];
        end else begin : g_pad
            assign w_a[i] = 1'b0;
            assign w_b[i] = 1'b0;
        end
        assign w_sum[i]   = w_a[i] ^ w_b[i] ^ w_c[i];
        assign w_c[i + 1] = (w_a[i] & w_b[i]) | (w_c[i] & (w_a[i] ^ w_b[i]));
    end

    // NOTE: w_next gets its default before the case so no path can infer a latch.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_LOAD:    if (w_in_evt && w_load_last) w_next = ST_COMPUTE;
            ST_COMPUTE: w_next = ST_SEND;
            ST_SEND:    if (w_out_evt && w_send_last) w_next = ST_LOAD;
            default:    w_next = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_LOAD;
        else        r_state <= w_next;
    end

    // NOTE: the operand register is reset so an abandoned load leaves no stale bytes behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_load_cnt <= '0;
            r_send_cnt <= '0;
            r_operand  <= '0;
            r_result   <= '0;
            r_carry    <= 1'b0;
        end else begin
            unique case (r_state)
                ST_LOAD: begin
                    if (w_in_evt) begin
                        r_operand[8*int'(r_load_cnt) +: 8] <= ui_in;
                        r_load_cnt <= w_load_last ? '0 : r_load_cnt + LOG2_BYTES_IN'(1);
                    end
                end
                ST_COMPUTE: begin
                    r_result   <= w_sum;
                    r_carry    <= w_c[BITS_OUT];
                    r_send_cnt <= '0;
                end
                ST_SEND: begin
                    if (w_out_evt) begin
                        r_send_cnt <= w_send_last ? '0 : r_send_cnt + LOG2_BYTES_OUT'(1);
                        if (w_send_last) r_load_cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        uo_out = 8'h00;
        if (r_state == ST_SEND) uo_out = r_result[8*int'(r_send_cnt) +: 8];
    end

    always_comb begin
        uio_out                = 8'h00;
        uio_out[UIO_IN_READY]  = (r_state == ST_LOAD);
        uio_out[UIO_OUT_VALID] = (r_state == ST_SEND);
        uio_out[UIO_BUSY]      = (r_state == ST_COMPUTE) || (r_state == ST_SEND);
        uio_out[UIO_CARRY]     = r_carry;
    end

    assign uio_oe = UIO_OE_MASK;

endmodule

// File: tb/tb_tt_um_toivoh_stream_tx.sv
// Directed and randomized bench for the streaming adder; expected sums come
// from plain 33-bit arithmetic on the loaded bytes.
module tb_tt_um_toivoh_stream_tx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int n_checks = 0;
    int n_pass   = 0;

    tt_um_toivoh_stream_tx dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [32:0] ref_sum(input logic [7:0] b[8]);
        logic [31:0] x;
        logic [31:0] y;
        x = {b[3], b[2], b[1], b[0]};
        y = {b[7], b[6], b[5], b[4]};
        return {1'b0, x} + {1'b0, y};
    endfunction

    // Raise in_valid, hold, drop. For the last byte, verify the COMPUTE cycle
    // and out_valid arriving two cycles after the in_evt cycle.
    task automatic load_byte(input logic [7:0] b, input bit last);
        ui_in     = b;
        uio_in[0] = 1'b1;
        step(3);
        if (last) begin
            check("compute_busy",      uio_out[4], 1'b1);
            check("compute_not_valid", uio_out[3], 1'b0);
            check("compute_uo_zero",   uo_out,     8'h00);
        end
        step(1);
        if (last) check("latency_out_valid", uio_out[3], 1'b1);
        uio_in[0] = 1'b0;
        step(3);
    endtask

    task automatic send_byte();
        uio_in[1] = 1'b1;
        step(4);
        uio_in[1] = 1'b0;
        step(3);
    endtask

    task automatic load_all(input logic [7:0] b[8], input bit latency);
        for (int i = 0; i < 8; i++) load_byte(b[i], latency && (i == 7));
    endtask

    task automatic wait_send();
        int k = 0;
        while (!uio_out[3] && k < 20) begin
            step(1);
            k++;
        end
        check("send_reached", uio_out[3], 1'b1);
    endtask

    task automatic send_range(input logic [7:0] b[8], input int first, input int last);
        logic [32:0] s;
        s = ref_sum(b);
        for (int i = first; i <= last; i++) begin
            check($sformatf("byte%0d", i), uo_out, s[8*i +: 8]);
            check("out_valid_busy", {uio_out[3], uio_out[4]}, 2'b11);
            check("carry", uio_out[5], s[32]);
            send_byte();
        end
    endtask

    task automatic idle_after(input logic [7:0] b[8]);
        logic [32:0] s;
        s = ref_sum(b);
        check("idle_status", uio_out, {2'b00, s[32], 5'b00100});
        check("idle_uo", uo_out, 8'h00);
    endtask

    task automatic full_txn(input logic [7:0] b[8], input bit latency);
        load_all(b, latency);
        wait_send();
        send_range(b, 0, 3);
        idle_after(b);
    endtask

    task automatic rand_bytes(output logic [7:0] b[8]);
        for (int i = 0; i < 8; i++) b[i] = 8'($urandom);
    endtask

    initial begin
        logic [7:0] seq[8];
        logic [7:0] ovf[8];
        logic [7:0] rb[8];
        logic [32:0] s;

        for (int i = 0; i < 8; i++) seq[i] = 8'(i + 1);
        ovf = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h01, 8'h00, 8'h00, 8'h00};

        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        #2;
        check("rst_uo",      uo_out,  8'h00);
        check("rst_uio_out", uio_out, 8'h04);
        check("uio_oe",      uio_oe,  8'h3C);
        step(2);
        rst_n = 1'b1;
        step(4);

        // Sequential operands: 0x04030201 + 0x08070605
        full_txn(seq, 1'b1);

        // Overflow: all-zero sum with carry out, carry persists afterwards
        full_txn(ovf, 1'b1);

        // Held-high out_ready advances one byte only
        rand_bytes(rb);
        s = ref_sum(rb);
        load_all(rb, 1'b0);
        wait_send();
        check("hold_byte0", uo_out, s[7:0]);
        uio_in[1] = 1'b1;
        step(20);
        check("hold_one_advance", uo_out, s[15:8]);
        check("hold_still_valid", uio_out[3], 1'b1);
        uio_in[1] = 1'b0;
        step(3);
        send_range(rb, 1, 3);
        idle_after(rb);

        // Reset in mid-SEND abandons the transfer
        load_all(seq, 1'b0);
        wait_send();
        send_range(seq, 0, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_uo",      uo_out,  8'h00);
        check("midrst_uio_out", uio_out, 8'h04);
        step(2);
        rst_n = 1'b1;
        step(3);
        full_txn(seq, 1'b0);

        // in_valid toggles during SEND are dropped
        rand_bytes(rb);
        s = ref_sum(rb);
        load_all(rb, 1'b0);
        wait_send();
        for (int i = 0; i < 3; i++) load_byte(8'hA5, 1'b0);
        check("drop_in_valid", uio_out[3], 1'b1);
        check("drop_in_byte0", uo_out, s[7:0]);
        send_range(rb, 0, 3);
        rand_bytes(rb);
        full_txn(rb, 1'b0);

        // in_valid already high when reset lifts produces no event
        uio_in[0] = 1'b1;
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(6);
        uio_in[0] = 1'b0;
        step(3);
        rand_bytes(rb);
        for (int i = 0; i < 7; i++) load_byte(rb[i], 1'b0);
        check("held_pin_still_load", uio_out, 8'h04);
        load_byte(rb[7], 1'b0);
        wait_send();
        send_range(rb, 0, 3);
        idle_after(rb);

        // Randomized transactions
        for (int t = 0; t < 4; t++) begin
            rand_bytes(rb);
            full_txn(rb, 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
